// File: rtl/ifetch_2432.sv
// ifetch_2432: sequential instruction prefetcher with a small {addr,instr} FIFO and redirect flush.
// Optional feature: define IFETCH_BYPASS_EN to forward ack data to the CPU when the FIFO is empty.
module ifetch_2432 #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 24,
    parameter int unsigned IW    = 24
) (
    input  logic          i_clk,
    input  logic          i_rstb,
    input  logic          i_clk_en,
    input  logic          i_cpu_hold,
    input  logic [AW-1:0] i_cpu_iaddr,
    output logic [IW-1:0] o_cpu_instr,
    output logic          o_cpu_clk_en,
    output logic          o_mem_req,
    output logic [AW-1:0] o_mem_addr,
    input  logic          i_mem_ack,
    input  logic [IW-1:0] i_mem_data
);
    localparam int unsigned PW   = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    typedef enum logic [1:0] {StIdle, StReq, StDiscard} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [AW-1:0] fetch_addr_q, fetch_addr_d;
    logic [AW-1:0] fifo_addr_q  [DEPTH];
    logic [IW-1:0] fifo_instr_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [PW:0]   count_q, count_d, count_after_pop, count_next;

    logic          head_valid, redirect, bypass, bypass_taken, pop, push, ack_ok;
    logic [AW-1:0] stream_addr;

    assign head_valid = (count_q != '0);

    // Address of the next instruction this unit would hand to the CPU.
    always_comb begin
        if (head_valid) begin
            stream_addr = fifo_addr_q[rd_ptr_q];
        end else if (state_q == StReq) begin
            stream_addr = mem_addr_q;
        end else begin
            stream_addr = fetch_addr_q;
        end
    end

    assign redirect = (stream_addr != i_cpu_iaddr) && (state_q != StDiscard);

`ifdef IFETCH_BYPASS_EN
    assign bypass = (state_q == StReq) && !head_valid && i_mem_ack && (mem_addr_q == i_cpu_iaddr);
`else
    assign bypass = 1'b0;
`endif

    assign o_cpu_clk_en = i_clk_en && (head_valid || bypass) && !redirect;

    always_comb begin
        o_cpu_instr = '0;
        if (!redirect) begin
            if (head_valid) begin
                o_cpu_instr = fifo_instr_q[rd_ptr_q];
            end else if (bypass) begin
                o_cpu_instr = i_mem_data;
            end
        end
    end

    assign pop             = o_cpu_clk_en && !i_cpu_hold && head_valid;
    assign bypass_taken    = o_cpu_clk_en && !i_cpu_hold && bypass;
    assign ack_ok          = (state_q == StReq) && i_mem_ack && !redirect;
    // A forwarded word the CPU consumed is not stored again.
    assign push            = ack_ok && !bypass_taken;
    assign count_after_pop = count_q - (PW+1)'(pop);
    assign count_next      = count_after_pop + (PW+1)'(push);

    assign o_mem_req  = (state_q != StIdle);
    assign o_mem_addr = mem_addr_q;

    always_comb begin
        state_d      = state_q;
        mem_addr_d   = mem_addr_q;
        fetch_addr_d = fetch_addr_q;
        rd_ptr_d     = rd_ptr_q + PW'(pop);
        wr_ptr_d     = wr_ptr_q + PW'(push);
        count_d      = count_next;
        if (redirect) begin
            rd_ptr_d     = '0;
            wr_ptr_d     = '0;
            count_d      = '0;
            fetch_addr_d = i_cpu_iaddr;
            case (state_q)
                StIdle: begin
                    state_d    = StReq;
                    mem_addr_d = i_cpu_iaddr;
                end
                StReq: begin
                    // An outstanding request must complete at its original address.
                    if (i_mem_ack) begin
                        mem_addr_d = i_cpu_iaddr;
                    end else begin
                        state_d = StDiscard;
                    end
                end
                default: ;
            endcase
        end else begin
            case (state_q)
                StIdle: begin
                    if (count_after_pop < FULL) begin
                        state_d    = StReq;
                        mem_addr_d = fetch_addr_q;
                    end
                end
                StReq: begin
                    if (i_mem_ack) begin
                        fetch_addr_d = mem_addr_q + AW'(1);
                        if (count_next < FULL) begin
                            mem_addr_d = mem_addr_q + AW'(1);
                        end else begin
                            state_d = StIdle;
                        end
                    end
                end
                StDiscard: begin
                    if (i_mem_ack) begin
                        state_d    = StReq;
                        mem_addr_d = fetch_addr_q;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rstb) begin
        if (!i_rstb) begin
            state_q      <= StIdle;
            mem_addr_q   <= '0;
            fetch_addr_q <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                fifo_addr_q[i]  <= '0;
                fifo_instr_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            mem_addr_q   <= mem_addr_d;
            fetch_addr_q <= fetch_addr_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            if (push) begin
                fifo_addr_q[wr_ptr_q]  <= mem_addr_q;
                fifo_instr_q[wr_ptr_q] <= i_mem_data;
            end
        end
    end

endmodule

// File: tb/tb_ifetch_2432.sv
// Directed bench for ifetch_2432: cycle table for the first fetches plus hand-written sequences.
`timescale 1ns/1ps
module tb_ifetch_2432;
    localparam int unsigned AW = 24;
    localparam int unsigned IW = 24;
`ifdef IFETCH_BYPASS_EN
    localparam int BYP = 1;
`else
    localparam int BYP = 0;
`endif

    logic          i_clk = 1'b0;
    logic          i_rstb;
    logic          i_clk_en;
    logic          i_cpu_hold;
    logic [AW-1:0] i_cpu_iaddr;
    logic [IW-1:0] o_cpu_instr;
    logic          o_cpu_clk_en;
    logic          o_mem_req;
    logic [AW-1:0] o_mem_addr;
    logic          i_mem_ack;
    logic [IW-1:0] i_mem_data;

    int checks   = 0;
    int failures = 0;

    ifetch_2432 dut (
        .i_clk       (i_clk),
        .i_rstb      (i_rstb),
        .i_clk_en    (i_clk_en),
        .i_cpu_hold  (i_cpu_hold),
        .i_cpu_iaddr (i_cpu_iaddr),
        .o_cpu_instr (o_cpu_instr),
        .o_cpu_clk_en(o_cpu_clk_en),
        .o_mem_req   (o_mem_req),
        .o_mem_addr  (o_mem_addr),
        .i_mem_ack   (i_mem_ack),
        .i_mem_data  (i_mem_data)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic          ce;
        logic          hold;
        logic [AW-1:0] ia;
        logic          ack;
        logic [IW-1:0] data;
        logic          req;
        logic [AW-1:0] addr;
        logic          en;
        logic [IW-1:0] instr;
    } vec_t;

    vec_t          vecs[8];
    logic [AW-1:0] acked_q[$];
    int            delivered;
    int            bubbles;

    function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
        return a ^ 24'h5A5A5A;
    endfunction

    // Ack data is always the memory word at the expected request address.
    function automatic vec_t mk(input logic ce, input logic hold, input logic [AW-1:0] ia,
                                input logic ack, input logic req, input logic [AW-1:0] addr,
                                input logic en, input logic [IW-1:0] instr);
        vec_t v;
        v.ce = ce; v.hold = hold; v.ia = ia; v.ack = ack; v.data = mem_word(addr);
        v.req = req; v.addr = addr; v.en = en; v.instr = instr;
        return v;
    endfunction

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic check_word(input string name, input logic [23:0] act, input logic [23:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    // Leaves the bench at a negedge with reset just released.
    task automatic do_reset(input logic [AW-1:0] ia);
        i_rstb = 1'b0; i_clk_en = 1'b1; i_cpu_hold = 1'b0;
        i_mem_ack = 1'b0; i_mem_data = '0; i_cpu_iaddr = ia;
        @(negedge i_clk);
        @(negedge i_clk);
        i_rstb = 1'b1;
    endtask

    // CPU advances on each delivery; memory acks every request in the cycle it is raised.
    task automatic run_stream(input int cycles);
        logic [AW-1:0] next_ia;
        logic          started;
        next_ia = i_cpu_iaddr; started = 1'b0;
        delivered = 0; bubbles = 0; acked_q.delete();
        for (int c = 0; c < cycles; c++) begin
            i_cpu_iaddr = next_ia;
            i_mem_ack   = o_mem_req;
            i_mem_data  = mem_word(o_mem_addr);
            if (o_mem_req) acked_q.push_back(o_mem_addr);
            #1;
            if (o_cpu_clk_en) begin
                check_word("stream instr", o_cpu_instr, mem_word(i_cpu_iaddr));
                delivered++;
                started = 1'b1;
                next_ia = i_cpu_iaddr + 24'd1;
            end else if (started) begin
                bubbles++;
            end
            tick();
        end
        i_mem_ack = 1'b0;
    endtask

    task automatic wait_deliver(input string name, input logic [IW-1:0] exp, input int bound);
        logic found;
        found = 1'b0;
        for (int c = 0; c < bound && !found; c++) begin
            i_mem_ack  = o_mem_req;
            i_mem_data = mem_word(o_mem_addr);
            #1;
            if (o_cpu_clk_en) begin
                check_word(name, o_cpu_instr, exp);
                found = 1'b1;
            end
            tick();
        end
        i_mem_ack = 1'b0;
        if (!found) begin
            checks++;
            failures++;
            $display("FAIL %s no delivery within %0d cycles", name, bound);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef IFETCH_BYPASS_EN
        vecs[0] = mk(1'b1, 1'b0, 24'h0, 1'b0, 1'b0, 24'h0, 1'b0, 24'h0);
        vecs[1] = mk(1'b1, 1'b0, 24'h0, 1'b0, 1'b1, 24'h0, 1'b0, 24'h0);
        vecs[2] = mk(1'b1, 1'b0, 24'h0, 1'b1, 1'b1, 24'h0, 1'b1, mem_word(24'h0));
        vecs[3] = mk(1'b1, 1'b0, 24'h1, 1'b0, 1'b1, 24'h1, 1'b0, 24'h0);
        vecs[4] = mk(1'b1, 1'b1, 24'h1, 1'b1, 1'b1, 24'h1, 1'b1, mem_word(24'h1));
        vecs[5] = mk(1'b0, 1'b0, 24'h1, 1'b0, 1'b1, 24'h2, 1'b0, mem_word(24'h1));
        vecs[6] = mk(1'b1, 1'b0, 24'h1, 1'b0, 1'b1, 24'h2, 1'b1, mem_word(24'h1));
        vecs[7] = mk(1'b1, 1'b0, 24'h2, 1'b0, 1'b1, 24'h2, 1'b0, 24'h0);
`else
        vecs[0] = mk(1'b1, 1'b0, 24'h0, 1'b0, 1'b0, 24'h0, 1'b0, 24'h0);
        vecs[1] = mk(1'b1, 1'b0, 24'h0, 1'b0, 1'b1, 24'h0, 1'b0, 24'h0);
        vecs[2] = mk(1'b1, 1'b0, 24'h0, 1'b1, 1'b1, 24'h0, 1'b0, 24'h0);
        vecs[3] = mk(1'b1, 1'b0, 24'h0, 1'b0, 1'b1, 24'h1, 1'b1, mem_word(24'h0));
        vecs[4] = mk(1'b1, 1'b0, 24'h1, 1'b0, 1'b1, 24'h1, 1'b0, 24'h0);
        vecs[5] = mk(1'b1, 1'b0, 24'h1, 1'b1, 1'b1, 24'h1, 1'b0, 24'h0);
        vecs[6] = mk(1'b0, 1'b0, 24'h1, 1'b0, 1'b1, 24'h2, 1'b0, mem_word(24'h1));
        vecs[7] = mk(1'b1, 1'b0, 24'h1, 1'b0, 1'b1, 24'h2, 1'b1, mem_word(24'h1));
`endif

        // First fetches after reset, ack one cycle after the request.
        do_reset(24'h0);
        for (int i = 0; i < 8; i++) begin
            i_clk_en    = vecs[i].ce;
            i_cpu_hold  = vecs[i].hold;
            i_cpu_iaddr = vecs[i].ia;
            i_mem_ack   = vecs[i].ack;
            i_mem_data  = vecs[i].data;
            #1;
            check_bit($sformatf("vec%0d req", i), o_mem_req, vecs[i].req);
            check_word($sformatf("vec%0d addr", i), o_mem_addr, vecs[i].addr);
            check_bit($sformatf("vec%0d clk_en", i), o_cpu_clk_en, vecs[i].en);
            check_word($sformatf("vec%0d instr", i), o_cpu_instr, vecs[i].instr);
            tick();
        end

        // CPU held: exactly DEPTH pushes, then no request until a pop.
        do_reset(24'h0);
        i_cpu_hold = 1'b1;
        acked_q.delete();
        for (int c = 0; c < 10; c++) begin
            i_mem_ack  = o_mem_req;
            i_mem_data = mem_word(o_mem_addr);
            if (o_mem_req) acked_q.push_back(o_mem_addr);
            #1;
            tick();
        end
        i_mem_ack = 1'b0;
        check_int("hold push count", acked_q.size(), 4);
        if (acked_q.size() == 4) begin
            for (int k = 0; k < 4; k++) check_word($sformatf("hold addr%0d", k), acked_q[k], 24'(k));
        end
        #1;
        check_bit("hold full req", o_mem_req, 1'b0);
        check_bit("hold full clk_en", o_cpu_clk_en, 1'b1);
        check_word("hold head instr", o_cpu_instr, mem_word(24'h0));
        tick();
        i_cpu_hold = 1'b0;
        #1;
        check_bit("hold release clk_en", o_cpu_clk_en, 1'b1);
        tick();
        i_cpu_hold = 1'b1; i_cpu_iaddr = 24'h1;
        #1;
        check_bit("refill req", o_mem_req, 1'b1);
        check_word("refill addr", o_mem_addr, 24'h4);
        check_word("refill head instr", o_cpu_instr, mem_word(24'h1));
        tick();

        // Streaming with same-cycle acks.
        do_reset(24'h0);
        run_stream(20);
        check_int("stream delivered", delivered, 18 + BYP);
        check_int("stream bubbles", bubbles, 0);
        if (acked_q.size() >= 5) begin
            for (int k = 0; k < 5; k++) check_word($sformatf("stream req%0d", k), acked_q[k], 24'(k));
        end else begin
            check_int("stream req count", acked_q.size(), 5);
        end

        // Jump while a request is outstanding.
        do_reset(24'h5);
        #1;
        check_bit("jump v0 req", o_mem_req, 1'b0);
        tick();
        i_cpu_iaddr = 24'h40;
        #1;
        check_bit("jump pending req", o_mem_req, 1'b1);
        check_word("jump pending addr", o_mem_addr, 24'h5);
        check_bit("jump pending clk_en", o_cpu_clk_en, 1'b0);
        tick();
        for (int c = 0; c < 2; c++) begin
            #1;
            check_word($sformatf("discard hold addr%0d", c), o_mem_addr, 24'h5);
            check_bit($sformatf("discard hold req%0d", c), o_mem_req, 1'b1);
            tick();
        end
        i_mem_ack = 1'b1; i_mem_data = mem_word(24'h5);
        #1;
        check_bit("discard ack clk_en", o_cpu_clk_en, 1'b0);
        check_word("discard ack instr", o_cpu_instr, 24'h0);
        tick();
        i_mem_ack = 1'b0;
        #1;
        check_bit("after discard req", o_mem_req, 1'b1);
        check_word("after discard addr", o_mem_addr, 24'h40);
        tick();
        wait_deliver("jump first instr", mem_word(24'h40), 4);

        // Address wrap with no redirect.
        do_reset(24'hFFFFFE);
        run_stream(8);
        check_int("wrap delivered", delivered, 6 + BYP);
        check_int("wrap bubbles", bubbles, 0);
        if (acked_q.size() >= 3) begin
            check_word("wrap req0", acked_q[0], 24'hFFFFFE);
            check_word("wrap req1", acked_q[1], 24'hFFFFFF);
            check_word("wrap req2", acked_q[2], 24'h000000);
        end else begin
            check_int("wrap req count", acked_q.size(), 3);
        end

        // Reset asserted while a request is pending; stale ack afterwards.
        do_reset(24'h5);
        tick();
        #1;
        check_bit("pre-reset req", o_mem_req, 1'b1);
        check_word("pre-reset addr", o_mem_addr, 24'h5);
        #1;
        i_rstb = 1'b0;
        #1;
        check_bit("async reset req", o_mem_req, 1'b0);
        check_word("async reset addr", o_mem_addr, 24'h0);
        check_bit("async reset clk_en", o_cpu_clk_en, 1'b0);
        check_word("async reset instr", o_cpu_instr, 24'h0);
        @(negedge i_clk);
        i_rstb = 1'b1; i_cpu_iaddr = 24'h0;
        i_mem_ack = 1'b1; i_mem_data = mem_word(24'h5);
        #1;
        check_bit("stale ack req", o_mem_req, 1'b0);
        check_bit("stale ack clk_en", o_cpu_clk_en, 1'b0);
        tick();
        i_mem_ack = 1'b0;
        #1;
        check_bit("post-reset req", o_mem_req, 1'b1);
        check_word("post-reset addr", o_mem_addr, 24'h0);
        check_bit("post-reset clk_en", o_cpu_clk_en, 1'b0);
        tick();
        wait_deliver("post-reset instr", mem_word(24'h0), 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
